// File: rtl/uart_tx_param.sv
// uart_tx_param: parametrised UART transmitter behind a small input FIFO.
// Queued words are serialised back-to-back, LSB first. Each frame is a start bit (0),
// DATA_BITS data bits, an optional parity bit and STOP_BITS stop bits (1).
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   s_data     in   word to transmit
//   s_valid    in   s_data valid
//   s_ready    out  FIFO can accept (transfer on s_valid && s_ready)
//   tx         out  UART line, idle high, registered
//   busy       out  frame on the line or FIFO non-empty
//   tx_done    out  one-cycle pulse at the end of each frame
//   fifo_count out  current FIFO occupancy
module uart_tx_param #(
  parameter int unsigned CLK_FREQ   = 50000000,
  parameter int unsigned BAUD_RATE  = 115200,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [DATA_BITS-1:0]        s_data,
  input  logic                        s_valid,
  output logic                        s_ready,
  output logic                        tx,
  output logic                        busy,
  output logic                        tx_done,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);
  localparam int unsigned PTR_W        = $clog2(FIFO_DEPTH);
  localparam int unsigned COUNT_W      = PTR_W + 1;
  localparam int unsigned BIT_W        = $clog2(DATA_BITS + 1);

  localparam logic [CNT_W-1:0]   CLK_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]   DATA_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0]   STOP_LAST = BIT_W'(STOP_BITS - 1);
  localparam logic [COUNT_W-1:0] DEPTH_L   = COUNT_W'(FIFO_DEPTH);

  if (CLKS_PER_BIT < 2 || DATA_BITS < 5 || DATA_BITS > 9 || PARITY > 2 ||
      STOP_BITS < 1 || STOP_BITS > 2 || FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_param_check
    $error("uart_tx_param: illegal parameter combination");
  end

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  // ---------------------------------------------------------------- input FIFO
  logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     r_wr_ptr, r_rd_ptr;
  logic [COUNT_W-1:0]   r_count;
  logic                 w_push, w_pop, w_fifo_nempty;

  assign s_ready       = (r_count < DEPTH_L);
  assign w_push        = s_valid && s_ready;
  assign w_fifo_nempty = (r_count != '0);
  assign fifo_count    = r_count;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= s_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + COUNT_W'(1);
        2'b01:   r_count <= r_count - COUNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // ---------------------------------------------------------------- transmitter
  state_e               r_state, w_state_d;
  logic [CNT_W-1:0]     r_clk_cnt, w_clk_cnt_d;
  logic [BIT_W-1:0]     r_bit_cnt, w_bit_cnt_d;
  logic [DATA_BITS-1:0] r_shift, w_shift_d;
  logic                 r_parity, w_parity_d;
  logic                 r_tx, w_tx_d;
  logic                 r_done, w_done_d;
  logic                 w_bit_end, w_frame_end;

  assign w_bit_end   = (r_clk_cnt == CLK_LAST);
  assign w_frame_end = (r_state == StStop) && w_bit_end && (r_bit_cnt == STOP_LAST);
  // Popping at the last stop-bit edge lets the next start bit follow with no idle gap.
  assign w_pop       = w_fifo_nempty && ((r_state == StIdle) || w_frame_end);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= StIdle;
      r_clk_cnt <= '0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_parity  <= 1'b0;
      r_tx      <= 1'b1;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_clk_cnt <= w_clk_cnt_d;
      r_bit_cnt <= w_bit_cnt_d;
      r_shift   <= w_shift_d;
      r_parity  <= w_parity_d;
      r_tx      <= w_tx_d;
      r_done    <= w_done_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      StIdle:   if (w_fifo_nempty) w_state_d = StStart;
      StStart:  if (w_bit_end) w_state_d = StData;
      StData:   if (w_bit_end && (r_bit_cnt == DATA_LAST)) begin
                  w_state_d = (PARITY != 0) ? StParity : StStop;
                end
      StParity: if (w_bit_end) w_state_d = StStop;
      StStop:   if (w_frame_end) w_state_d = w_fifo_nempty ? StStart : StIdle;
      default:  w_state_d = StIdle;
    endcase
  end

  always_comb begin
    w_clk_cnt_d = r_clk_cnt + CNT_W'(1);
    w_bit_cnt_d = r_bit_cnt;
    w_shift_d   = r_shift;
    w_parity_d  = r_parity;
    w_done_d    = w_frame_end;

    if ((r_state == StIdle) || w_bit_end) w_clk_cnt_d = '0;
    if (w_bit_end && ((r_state == StData) || (r_state == StStop))) begin
      w_bit_cnt_d = r_bit_cnt + BIT_W'(1);
    end
    if (w_state_d != r_state) w_bit_cnt_d = '0;

    if (w_pop) begin
      w_shift_d  = r_mem[r_rd_ptr];
      w_parity_d = (^r_mem[r_rd_ptr]) ^ (PARITY == 1);
    end else if ((r_state == StData) && w_bit_end) begin
      w_shift_d = r_shift >> 1;
    end

    // Line level for the bit that starts on the coming edge.
    case (w_state_d)
      StStart:  w_tx_d = 1'b0;
      StData:   w_tx_d = w_shift_d[0];
      StParity: w_tx_d = r_parity;
      default:  w_tx_d = 1'b1;
    endcase
  end

  assign tx      = r_tx;
  assign tx_done = r_done;
  assign busy    = (r_state != StIdle) || w_fifo_nempty;

endmodule

// File: tb/tb_uart_tx_param.sv
// Bench for uart_tx_param: four instances (8N1, 8E1, 8O1, 7N2) at 10 clocks per bit.
// A line-level model predicts tx/tx_done/busy/s_ready/fifo_count every cycle from the
// push times alone; directed table vectors and hand sequences cover the corner cases.
module tb_uart_tx_param;
  localparam int CPB   = 10;
  localparam int NI    = 4;
  localparam int MAXF  = 256;
  localparam int DEPTH = 4;
  localparam int NV    = 8;

  typedef struct {
    int         inst;
    logic [8:0] data;
    int         len;
    logic [11:0] bits;
    int         nbits;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [NI-1:0] rst_n, valid, ready_v, tx_v, busy_v, done_v;
  logic [8:0]    s_data;
  logic [2:0]    cnt_a [NI];

  uart_tx_param #(.CLK_FREQ(1000), .BAUD_RATE(100), .DATA_BITS(8), .PARITY(0),
                  .STOP_BITS(1), .FIFO_DEPTH(4)) u_8n1 (
    .clk(clk), .rst_n(rst_n[0]), .s_data(s_data[7:0]), .s_valid(valid[0]),
    .s_ready(ready_v[0]), .tx(tx_v[0]), .busy(busy_v[0]), .tx_done(done_v[0]),
    .fifo_count(cnt_a[0]));
  uart_tx_param #(.CLK_FREQ(1000), .BAUD_RATE(100), .DATA_BITS(8), .PARITY(2),
                  .STOP_BITS(1), .FIFO_DEPTH(4)) u_8e1 (
    .clk(clk), .rst_n(rst_n[1]), .s_data(s_data[7:0]), .s_valid(valid[1]),
    .s_ready(ready_v[1]), .tx(tx_v[1]), .busy(busy_v[1]), .tx_done(done_v[1]),
    .fifo_count(cnt_a[1]));
  uart_tx_param #(.CLK_FREQ(1000), .BAUD_RATE(100), .DATA_BITS(8), .PARITY(1),
                  .STOP_BITS(1), .FIFO_DEPTH(4)) u_8o1 (
    .clk(clk), .rst_n(rst_n[2]), .s_data(s_data[7:0]), .s_valid(valid[2]),
    .s_ready(ready_v[2]), .tx(tx_v[2]), .busy(busy_v[2]), .tx_done(done_v[2]),
    .fifo_count(cnt_a[2]));
  uart_tx_param #(.CLK_FREQ(1000), .BAUD_RATE(100), .DATA_BITS(7), .PARITY(0),
                  .STOP_BITS(2), .FIFO_DEPTH(4)) u_7n2 (
    .clk(clk), .rst_n(rst_n[3]), .s_data(s_data[6:0]), .s_valid(valid[3]),
    .s_ready(ready_v[3]), .tx(tx_v[3]), .busy(busy_v[3]), .tx_done(done_v[3]),
    .fifo_count(cnt_a[3]));

  // Model state: per instance, every accepted word with its push edge and start edge.
  int         fr_push  [NI][MAXF];
  int         fr_start [NI][MAXF];
  logic [8:0] fr_word  [NI][MAXF];
  int         n_fr [NI];
  int         line_free [NI];
  int         cyc;
  int         n_cmp, n_fail;
  logic       abort;
  logic [NI-1:0] last_push;

  function automatic int dbits_of(int i);
    return (i == 3) ? 7 : 8;
  endfunction
  function automatic int par_of(int i);
    return (i == 1) ? 2 : ((i == 2) ? 1 : 0);
  endfunction
  function automatic int stop_of(int i);
    return (i == 3) ? 2 : 1;
  endfunction
  function automatic int flen(int i);
    return (1 + dbits_of(i) + ((par_of(i) != 0) ? 1 : 0) + stop_of(i)) * CPB;
  endfunction

  // Bit idx of the frame carrying word w: start, data LSB first, parity, stops.
  function automatic logic frame_bit(int i, logic [8:0] w, int idx);
    int   db;
    logic p;
    db = dbits_of(i);
    p  = 1'b0;
    for (int b = 0; b < db; b++) p = p ^ w[b];
    if (par_of(i) == 1) p = ~p;
    if (idx == 0) return 1'b0;
    if (idx <= db) return w[idx-1];
    if (par_of(i) != 0 && idx == db + 1) return p;
    return 1'b1;
  endfunction

  // Expected {tx, tx_done, busy, s_ready, fifo_count} just after edge k.
  function automatic logic [6:0] model_out(int i, int k);
    logic t, d, b;
    int   c, s, e;
    t = 1'b1; d = 1'b0; b = 1'b0; c = 0;
    for (int f = 0; f < n_fr[i]; f++) begin
      s = fr_start[i][f];
      e = s + flen(i);
      if (k >= s && k < e) t = frame_bit(i, fr_word[i][f], (k - s) / CPB);
      if (k == e) d = 1'b1;
      if (fr_push[i][f] <= k && k < e) b = 1'b1;
      if (fr_push[i][f] <= k && k < s) c++;
    end
    return {t, d, b, (c < DEPTH), 3'(c)};
  endfunction

  task automatic add_frame(int i);
    int s;
    s = (line_free[i] > cyc + 1) ? line_free[i] : cyc + 1;
    if (n_fr[i] < MAXF) begin
      fr_push[i][n_fr[i]]  = cyc;
      fr_start[i][n_fr[i]] = s;
      fr_word[i][n_fr[i]]  = s_data & ((9'h1 << dbits_of(i)) - 9'h1);
      n_fr[i]++;
    end
    line_free[i] = s + flen(i);
  endtask

  task automatic cmp(string name, int got, int want);
    n_cmp++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d", name, got, want);
    end
  endtask

  task automatic check_cycle(int i);
    logic [6:0] want, got;
    want = model_out(i, cyc);
    got  = {tx_v[i], done_v[i], busy_v[i], ready_v[i], cnt_a[i]};
    n_cmp++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL line_i%0d cycle %0d: got %b required %b (tx,done,busy,ready,count)",
               i, cyc, got, want);
      if (n_fail >= 100) abort = 1'b1;
    end
  endtask

  // One clock: decide pushes from the model's ready, advance, then check all lines.
  task automatic step();
    logic [6:0] m;
    for (int i = 0; i < NI; i++) begin
      m = model_out(i, cyc);
      last_push[i] = valid[i] && rst_n[i] && m[3];
    end
    @(posedge clk);
    cyc++;
    for (int i = 0; i < NI; i++) if (last_push[i]) add_frame(i);
    #1;
    for (int i = 0; i < NI; i++) check_cycle(i);
  endtask

  initial begin
    vec_t        tbl [NV];
    int          ii, e0, e1, off, done_at, busy_fall, first_low, npulse, tx_at_push;
    int          idx, nd, drop_cnt, dones, lows;
    int          dedge [8];
    logic [11:0] got_bits;

    tbl[0] = '{inst: 0, data: 9'h0A5, len: 100, bits: 12'h34A, nbits: 10};
    tbl[1] = '{inst: 1, data: 9'h0A5, len: 110, bits: 12'h54A, nbits: 11};
    tbl[2] = '{inst: 2, data: 9'h0A5, len: 110, bits: 12'h74A, nbits: 11};
    tbl[3] = '{inst: 3, data: 9'h041, len: 100, bits: 12'h382, nbits: 10};
    tbl[4] = '{inst: 0, data: 9'h000, len: 100, bits: 12'h200, nbits: 10};
    tbl[5] = '{inst: 1, data: 9'h001, len: 110, bits: 12'h602, nbits: 11};
    tbl[6] = '{inst: 2, data: 9'h0FF, len: 110, bits: 12'h7FE, nbits: 11};
    tbl[7] = '{inst: 3, data: 9'h07F, len: 100, bits: 12'h3FE, nbits: 10};

    cyc = 0; n_cmp = 0; n_fail = 0; abort = 1'b0; last_push = '0;
    valid = '0; s_data = '0; rst_n = '1;
    for (int i = 0; i < NI; i++) begin
      n_fr[i] = 0;
      line_free[i] = 0;
    end

    // Reset state, checked before any clock edge.
    #2 rst_n = '0;
    #1;
    for (int i = 0; i < NI; i++) begin
      cmp($sformatf("reset_i%0d", i),
          int'({tx_v[i], done_v[i], busy_v[i], ready_v[i], cnt_a[i]}), 7'b1001000);
    end
    step();
    step();
    rst_n = '1;
    step();

    // Directed single frames.
    for (int r = 0; r < NV && !abort; r++) begin
      ii = tbl[r].inst;
      s_data = tbl[r].data;
      valid[ii] = 1'b1;
      step();
      e0 = cyc;
      valid[ii] = 1'b0;
      tx_at_push = int'(tx_v[ii]);
      got_bits = '0; done_at = -1; busy_fall = -1; first_low = -1; npulse = 0;
      for (int t = 0; t < tbl[r].len + 6; t++) begin
        step();
        off = cyc - e0;
        if ((off - 1) % CPB == 5 && (off - 1) / CPB < tbl[r].nbits) begin
          got_bits[(off - 1) / CPB] = tx_v[ii];
        end
        if (!tx_v[ii] && first_low < 0) first_low = off;
        if (done_v[ii]) begin
          npulse++;
          if (done_at < 0) done_at = off;
        end
        if (!busy_v[ii] && busy_fall < 0) busy_fall = off;
      end
      cmp($sformatf("vec%0d_bits", r), int'(got_bits), int'(tbl[r].bits));
      cmp($sformatf("vec%0d_idle_at_push", r), tx_at_push, 1);
      cmp($sformatf("vec%0d_start_offset", r), first_low, 1);
      cmp($sformatf("vec%0d_done_offset", r), done_at, tbl[r].len + 1);
      cmp($sformatf("vec%0d_done_pulses", r), npulse, 1);
      cmp($sformatf("vec%0d_busy_fall", r), busy_fall, tbl[r].len + 1);
    end

    // Burst of six words with s_valid held: FIFO fills, frames run back-to-back.
    idx = 0; nd = 0; drop_cnt = -1;
    for (int t = 0; t < 900 && nd < 6 && !abort; t++) begin
      s_data = 9'(idx + 1);
      valid[0] = (idx < 6);
      step();
      if (last_push[0]) idx++;
      if (!ready_v[0] && drop_cnt < 0) drop_cnt = int'(cnt_a[0]);
      if (done_v[0]) begin
        if (nd < 8) dedge[nd] = cyc;
        nd++;
      end
    end
    valid[0] = 1'b0;
    cmp("burst_pulses", nd, 6);
    cmp("burst_ready_drop_count", drop_cnt, 4);
    if (nd >= 6) begin
      for (int j = 1; j < 6; j++) cmp($sformatf("burst_spacing%0d", j), dedge[j] - dedge[j-1], 100);
    end
    repeat (5) step();

    // Reset 35 cycles into a frame with two words still queued.
    s_data = 9'h011;
    valid[0] = 1'b1;
    step();
    e1 = cyc;
    s_data = 9'h022;
    step();
    s_data = 9'h033;
    step();
    valid[0] = 1'b0;
    cmp("rst_queued", int'(cnt_a[0]), 2);
    while (cyc < e1 + 35) step();
    cmp("rst_tx_low_before", int'(tx_v[0]), 0);
    #2 rst_n[0] = 1'b0;
    #1;
    cmp("rst_tx", int'(tx_v[0]), 1);
    cmp("rst_count", int'(cnt_a[0]), 0);
    cmp("rst_busy", int'(busy_v[0]), 0);
    cmp("rst_ready", int'(ready_v[0]), 1);
    n_fr[0] = 0;
    line_free[0] = 0;
    step();
    step();
    step();
    rst_n[0] = 1'b1;
    dones = 0; lows = 0;
    repeat (300) begin
      step();
      if (done_v[0]) dones++;
      if (!tx_v[0]) lows++;
    end
    cmp("post_rst_done_pulses", dones, 0);
    cmp("post_rst_tx_low_cycles", lows, 0);

    // Random traffic on all four lines against the model.
    for (int t = 0; t < 6000 && !abort; t++) begin
      s_data = 9'($urandom_range(0, 511));
      for (int i = 0; i < NI; i++) begin
        valid[i] = ($urandom_range(0, 24) == 0) && (n_fr[i] < MAXF - 4);
      end
      step();
    end
    valid = '0;
    for (int t = 0; t < 800 && !abort; t++) step();
    for (int i = 0; i < NI; i++) cmp($sformatf("drain_busy_i%0d", i), int'(busy_v[i]), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
